decode_stage: RTL

//   Fetch-to-decode pipeline stage of the RISC-V core; sits directly upstream of imm_gen.

---
 rtl/decode_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - fetch-to-decode stage: 2-entry skid FIFO with imm_sel/register pre-decode.
// Optional DECODE_ILLEGAL_CHECK_EN adds a per-entry out_illegal flag.
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int IMM_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [PC_W-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [24:0]          out_inst_in,
    output logic [IMM_SEL_W-1:0] out_imm_sel,
    output logic [6:0]           out_opcode,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
`ifdef DECODE_ILLEGAL_CHECK_EN
    output logic                 out_illegal,
`endif
    output logic [4:0]           out_rs2
);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [24:0]          inst_hi;
        logic [6:0]           opcode;
        logic [IMM_SEL_W-1:0] imm_sel;
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic                 illegal;
`endif
    } entry_t;

    function automatic logic [IMM_SEL_W-1:0] dec_sel(input logic [6:0] opc, input logic f3_msb);
        case (opc)
            7'b0000011, 7'b0010011, 7'b1100111: dec_sel = IMM_SEL_W'(1);
            7'b0100011:                         dec_sel = IMM_SEL_W'(2);
            7'b1100011:                         dec_sel = IMM_SEL_W'(3);
            7'b0110111, 7'b0010111:             dec_sel = IMM_SEL_W'(4);
            7'b1101111:                         dec_sel = IMM_SEL_W'(5);
            7'b1110011:                         dec_sel = f3_msb ? IMM_SEL_W'(6) : IMM_SEL_W'(1);
            default:                            dec_sel = '0;
        endcase
    endfunction

`ifdef DECODE_ILLEGAL_CHECK_EN
    function automatic logic is_illegal(input logic [6:0] opc);
        case (opc)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011: is_illegal = 1'b0;
            default:                                                    is_illegal = 1'b1;
        endcase
    endfunction
`endif

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    entry_t     out_q, out_d, new_e;
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        new_e         = '0;
        new_e.pc      = in_pc;
        new_e.inst_hi = in_inst[31:7];
        new_e.opcode  = in_inst[6:0];
        new_e.imm_sel = dec_sel(in_inst[6:0], in_inst[14]);
`ifdef DECODE_ILLEGAL_CHECK_EN
        new_e.illegal = is_illegal(in_inst[6:0]) | (in_inst[1:0] != 2'b11);
        if (new_e.illegal) new_e.imm_sel = '0;
`endif
    end

    // The output register is reloaded with the post-update head, so it holds the
    // last head when the FIFO drains and only clears on reset/flush.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            out_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_e;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
            if (count_d != 2'd0) out_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            out_q    <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            out_q    <= out_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign out_pc      = out_q.pc;
    assign out_inst_in = out_q.inst_hi;
    assign out_opcode  = out_q.opcode;
    assign out_imm_sel = out_q.imm_sel;
    assign out_rd      = out_q.inst_hi[4:0];
    assign out_rs1     = out_q.inst_hi[12:8];
    assign out_rs2     = out_q.inst_hi[17:13];
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign out_illegal = out_q.illegal;
`endif

endmodule
